// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_if
//  Description : Start/done request and result bundle between the processor
//                control unit (master) and the registered ALU (slave).
//  Ports       : start, operation, operand1, operand2   (master -> slave)
//                busy, done, dout, Z, N, C, err         (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
  parameter int DWIDTH = 16
);
  logic              start;
  logic [3:0]        operation;
  logic [DWIDTH-1:0] operand1;
  logic [DWIDTH-1:0] operand2;
  logic              busy;
  logic              done;
  logic [DWIDTH-1:0] dout;
  logic              Z;
  logic              N;
  logic              C;
  logic              err;

  modport master (
    output start, operation, operand1, operand2,
    input  busy, done, dout, Z, N, C, err
  );

  modport slave (
    input  start, operation, operand1, operand2,
    output busy, done, dout, Z, N, C, err
  );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Registered ALU with start/done handshake. Single-cycle ops
//                finish one edge after accept; multiply runs an iterative
//                shift-add sequence of DWIDTH steps. Result and Z/N/C/err
//                flags are held in registers and change only on done cycles
//                or on reset.
//  Ports       : clk  - rising-edge clock
//                rst  - synchronous active-high reset
//                bus  - alu_seq_if.slave (start/operation/operands in,
//                       busy/done/dout/Z/N/C/err out)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int DWIDTH = 16,
  parameter int CWIDTH = $clog2(DWIDTH) + 1
) (
  input  wire logic clk,
  input  wire logic rst,
  alu_seq_if.slave  bus
);

  // --------------------------------------------------------------------------
  // Opcodes
  // --------------------------------------------------------------------------
  localparam logic [3:0] OP_PASS = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_SHL1 = 4'b0011;
  localparam logic [3:0] OP_SHL2 = 4'b0100;
  localparam logic [3:0] OP_SHR4 = 4'b0101;
  localparam logic [3:0] OP_INC  = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_NOT  = 4'b1010;
  localparam logic [3:0] OP_SHLB = 4'b1011;
  localparam logic [3:0] OP_SHRB = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1101;

  // --------------------------------------------------------------------------
  // FSM encoding
  // --------------------------------------------------------------------------
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  localparam logic [CWIDTH-1:0] LAST_STEP = CWIDTH'(DWIDTH - 1);

  logic [0:0] state_q;
  logic [0:0] state_d;

  // Result / flag registers
  logic [DWIDTH-1:0] dout_q;
  logic              z_q;
  logic              n_q;
  logic              c_q;
  logic              err_q;
  logic              done_q;

  // Multiply datapath: multiplicand shifts left, multiplier shifts right,
  // the double-width accumulator gathers partial products.
  logic [2*DWIDTH-1:0] mcand_q;
  logic [DWIDTH-1:0]   mplier_q;
  logic [2*DWIDTH-1:0] acc_q;
  logic [CWIDTH-1:0]   cnt_q;

  logic [2*DWIDTH-1:0] acc_d;
  logic [DWIDTH-1:0]   alu_res_d;
  logic                alu_c_d;
  logic                alu_err_d;

  logic                accept;
  logic                is_mul;
  logic                last_step;
  logic                busy_d;

  logic [DWIDTH:0]     sum_w;
  logic [DWIDTH:0]     inc_w;
  logic [CWIDTH-2:0]   shamt_w;

  // busy is the gate on accept: a start seen while a multiply runs is dropped.
  assign accept    = bus.start && (state_q == S_IDLE);
  assign is_mul    = (bus.operation == OP_MUL);
  assign last_step = (state_q == S_MUL) && (cnt_q == LAST_STEP);

  assign sum_w   = {1'b0, bus.operand1} + {1'b0, bus.operand2};
  assign inc_w   = {1'b0, bus.operand1} + {{DWIDTH{1'b0}}, 1'b1};
  assign shamt_w = bus.operand2[CWIDTH-2:0];

  // One shift-add step; on the final step this value is also the product.
  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : {(2*DWIDTH){1'b0}});

  // --------------------------------------------------------------------------
  // Single-cycle operation result
  // --------------------------------------------------------------------------
  always_comb begin : p_alu
    alu_res_d = '0;
    alu_c_d   = 1'b0;
    alu_err_d = 1'b0;
    case (bus.operation)
      OP_PASS: alu_res_d = bus.operand1;
      OP_ADD: begin
        alu_res_d = sum_w[DWIDTH-1:0];
        alu_c_d   = sum_w[DWIDTH];
      end
      OP_SUB: begin
        alu_res_d = bus.operand1 - bus.operand2;
        alu_c_d   = (bus.operand1 < bus.operand2);
      end
      OP_SHL1: begin
        alu_res_d = bus.operand1 << 1;
        alu_c_d   = bus.operand1[DWIDTH-1];
      end
      OP_SHL2: begin
        alu_res_d = bus.operand1 << 2;
        alu_c_d   = bus.operand1[DWIDTH-2];
      end
      OP_SHR4: alu_res_d = bus.operand1 >> 4;
      OP_INC: begin
        alu_res_d = inc_w[DWIDTH-1:0];
        alu_c_d   = inc_w[DWIDTH];
      end
      OP_AND:  alu_res_d = bus.operand1 & bus.operand2;
      OP_OR:   alu_res_d = bus.operand1 | bus.operand2;
      OP_XOR:  alu_res_d = bus.operand1 ^ bus.operand2;
      OP_NOT:  alu_res_d = ~bus.operand1;
      OP_SHLB: alu_res_d = bus.operand1 << shamt_w;
      OP_SHRB: alu_res_d = bus.operand1 >> shamt_w;
      OP_MUL:  alu_res_d = '0;  // handled by the multi-cycle path
      default: alu_err_d = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin : p_state
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin : p_next
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept && is_mul) state_d = S_MUL;
      S_MUL:  if (last_step)        state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin : p_fsm_out
    busy_d = 1'b0;
    if (state_q == S_MUL) busy_d = 1'b1;
  end

  // --------------------------------------------------------------------------
  // Datapath and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin : p_data
    if (rst) begin
      dout_q   <= '0;
      z_q      <= 1'b1;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;

      if (accept && !is_mul) begin
        dout_q <= alu_res_d;
        z_q    <= (alu_res_d == '0);
        n_q    <= alu_res_d[DWIDTH-1];
        c_q    <= alu_c_d;
        err_q  <= alu_err_d;
        done_q <= 1'b1;
      end

      // Operands are captured here so later input changes cannot disturb
      // an in-flight multiply.
      if (accept && is_mul) begin
        mcand_q  <= {{DWIDTH{1'b0}}, bus.operand1};
        mplier_q <= bus.operand2;
        acc_q    <= '0;
        cnt_q    <= '0;
      end

      if (state_q == S_MUL) begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CWIDTH'(1);
        if (last_step) begin
          dout_q <= acc_d[DWIDTH-1:0];
          z_q    <= (acc_d[DWIDTH-1:0] == '0);
          n_q    <= acc_d[DWIDTH-1];
          c_q    <= |acc_d[2*DWIDTH-1:DWIDTH];
          err_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign bus.busy = busy_d;
  assign bus.done = done_q;
  assign bus.dout = dout_q;
  assign bus.Z    = z_q;
  assign bus.N    = n_q;
  assign bus.C    = c_q;
  assign bus.err  = err_q;

endmodule
`default_nettype wire
